// File: rtl/sonar_scan.sv
// -----------------------------------------------------------------------------
// sonar_scan
//
// Purpose:
//   Front end of the obstacle-avoidance controller. Fires four trigger/echo
//   ultrasonic rangers one at a time in round-robin order. Only one ranger is
//   active at a time, so one sensor's ping cannot be heard as another sensor's
//   echo. The block times each echo pulse and compares the width with a
//   distance threshold. It keeps one clear(1)/obstacle(0) flag per sensor.
//
// Ports:
//   clk_100        in   1   system clock (100 kHz), all logic on rising edge
//   rst            in   1   synchronous active-high reset
//   echo           in   4   raw asynchronous echo inputs, bit i = sensor i
//   trig           out  4   trigger outputs, one-hot or zero
//   distance_flag  out  4   [3] left, [2] right, [1] front-left, [0] front-right
//   meas_valid     out  1   one-cycle pulse when a measurement completes
//   meas_sel       out  2   sensor index of the result on meas_cnt
//   meas_cnt       out  12  last echo width in cycles (0..MAX_CNT)
//
// Optional feature (macro SONAR_FILTER_EN):
//   When defined, a flag changes only after two consecutive readings of the
//   same sensor agree with each other and differ from the current flag. When
//   undefined, each reading drives its flag directly.
// -----------------------------------------------------------------------------
module sonar_scan #(
  parameter int TRIG_CYC = 2,
  parameter int RISE_TO  = 100,
  parameter int MAX_CNT  = 3800,
  parameter int THRESH   = 174,
  parameter int GAP_CYC  = 6000
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic [3:0]  echo,
  output logic [3:0]  trig,
  output logic [3:0]  distance_flag,
  output logic        meas_valid,
  output logic [1:0]  meas_sel,
  output logic [11:0] meas_cnt
);

  localparam logic [1:0] ST_TRIG      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam logic [15:0] TRIG_LAST = 16'(TRIG_CYC - 1);
  localparam logic [15:0] RISE_LAST = 16'(RISE_TO - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [11:0] MAX_VAL   = 12'(MAX_CNT);
  localparam logic [11:0] SAT_PRE   = 12'(MAX_CNT - 1);
  localparam logic [11:0] THR_VAL   = 12'(THRESH);

  logic [3:0]  echo_meta;
  logic [3:0]  echo_sync;
  logic [1:0]  state;
  logic [1:0]  sel;
  logic [15:0] cnt;
  logic [11:0] echo_cnt;
  logic        echo_now;
  logic        done;
  logic [11:0] result;
  logic        decision;

`ifdef SONAR_FILTER_EN
  logic [3:0]  prev_dec;
`endif

  // The echo lines come straight from the rangers with no relation to our
  // clock, so each bit is passed through two flops before any use.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      echo_meta <= 4'b0000;
      echo_sync <= 4'b0000;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  assign echo_now = echo_sync[sel];

  // A measurement finishes in one of three ways: the echo never rose
  // (timeout), the echo fell, or the echo counter reached saturation.
  // Timeout and saturation both report MAX_CNT, which reads as "no target".
  // The saturation test looks one count ahead. The result is then reported in
  // the same cycle the counter would reach MAX_CNT, without waiting for the
  // echo to fall.
  always_comb begin
    done   = 1'b0;
    result = echo_cnt;
    case (state)
      ST_WAIT_RISE: begin
        if (!echo_now && cnt == RISE_LAST) begin
          done   = 1'b1;
          result = MAX_VAL;
        end
      end
      ST_MEASURE: begin
        if (!echo_now) begin
          done   = 1'b1;
          result = echo_cnt;
        end else if (echo_cnt >= SAT_PRE) begin
          done   = 1'b1;
          result = MAX_VAL;
        end
      end
      default: begin
      end
    endcase
    decision = (result >= THR_VAL);
  end

  // Result registration. This logic only runs on the cycle that enters GAP,
  // so at most one flag bit can change per measurement.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      meas_valid    <= 1'b0;
      meas_sel      <= 2'd0;
      meas_cnt      <= 12'd0;
      distance_flag <= 4'b1111;
`ifdef SONAR_FILTER_EN
      prev_dec      <= 4'b1111;
`endif
    end else begin
      meas_valid <= done;
      if (done) begin
        meas_sel <= sel;
        meas_cnt <= result;
`ifdef SONAR_FILTER_EN
        if (decision == prev_dec[sel] && decision != distance_flag[sel]) begin
          distance_flag[sel] <= decision;
        end
        prev_dec[sel] <= decision;
`else
        distance_flag[sel] <= decision;
`endif
      end
    end
  end

  // Scan sequencer. trig is a register. It goes high on the same edge that
  // enters TRIG, so the pulse lasts exactly TRIG_CYC cycles. The one exception
  // is the first TRIG after reset: it is entered with trig low, so the first
  // cycle only raises the pulse. cnt is cleared on every state change.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state    <= ST_TRIG;
      sel      <= 2'd0;
      cnt      <= 16'd0;
      echo_cnt <= 12'd0;
      trig     <= 4'b0000;
    end else begin
      case (state)
        ST_TRIG: begin
          if (trig == 4'b0000) begin
            trig <= 4'b0001 << sel;
            cnt  <= 16'd0;
          end else if (cnt == TRIG_LAST) begin
            trig  <= 4'b0000;
            cnt   <= 16'd0;
            state <= ST_WAIT_RISE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT_RISE: begin
          if (echo_now) begin
            echo_cnt <= 12'd1;
            cnt      <= 16'd0;
            state    <= ST_MEASURE;
          end else if (done) begin
            cnt   <= 16'd0;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_MEASURE: begin
          if (done) begin
            cnt   <= 16'd0;
            state <= ST_GAP;
          end else begin
            echo_cnt <= echo_cnt + 12'd1;
            cnt      <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt == GAP_LAST) begin
            sel   <= sel + 2'd1;
            trig  <= 4'b0001 << (sel + 2'd1);
            cnt   <= 16'd0;
            state <= ST_TRIG;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scan.sv
// -----------------------------------------------------------------------------
// tb_sonar_scan
//
// Purpose:
//   Drives a scripted sequence of echo pulses into sonar_scan. Every
//   expectation comes from a small behavioural model of the flags. Each
//   expected measurement is queued when its echo is driven, then popped and
//   compared when the DUT raises meas_valid. The settle gap is shortened so
//   that several full sweeps fit in a short run.
// -----------------------------------------------------------------------------
module tb_sonar_scan;

  localparam int TRIG_CYC   = 2;
  localparam int RISE_TO    = 100;
  localparam int MAX_CNT    = 3800;
  localparam int THRESH     = 174;
  localparam int GAP_CYC    = 300;
  localparam int ECHO_DELAY = 20;
  localparam int PLAN_LEN   = 31;

  typedef struct {
    int         sel;
    int         cnt;
    logic [3:0] flag;
    int         lat;
  } exp_t;

  logic        clk_100 = 1'b0;
  logic        rst     = 1'b1;
  logic [3:0]  echo    = 4'b0000;
  logic [3:0]  trig;
  logic [3:0]  distance_flag;
  logic        meas_valid;
  logic [1:0]  meas_sel;
  logic [11:0] meas_cnt;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          raise_cyc = 0;
  logic [3:0]  model_flag = 4'b1111;
  logic [3:0]  model_prev = 4'b1111;

  // Width 0 means no echo (timeout). Width -1 means: reset mid-measurement.
  // Width >= MAX_CNT means the echo stays high past saturation.
  int plan_sel[PLAN_LEN] = '{0, 1, 2, 3,
                             0, 1, 2, 3,
                             0, 1, 2, 3,
                             0, 1, 2,
                             0, 1, 2, 3,
                             0, 1, 2, 3,
                             0, 1, 2, 3,
                             0, 1, 2, 3};
  int plan_width[PLAN_LEN] = '{0,   0,   0,   0,
                               174, 100, 200, 0,
                               173, 200, 50,  3900,
                               174, 300, -1,
                               10,  0,   50,  0,
                               0,   0,   300, 0,
                               0,   0,   50,  0,
                               0,   0,   50,  0};

  sonar_scan #(
    .TRIG_CYC(TRIG_CYC),
    .RISE_TO (RISE_TO),
    .MAX_CNT (MAX_CNT),
    .THRESH  (THRESH),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk_100      (clk_100),
    .rst          (rst),
    .echo         (echo),
    .trig         (trig),
    .distance_flag(distance_flag),
    .meas_valid   (meas_valid),
    .meas_sel     (meas_sel),
    .meas_cnt     (meas_cnt)
  );

  always #5 clk_100 = ~clk_100;

  always @(posedge clk_100) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Flag model: a reading of THRESH cycles or more means the path is clear.
  task automatic pushResult(input int s, input int res, input int lat);
    exp_t e;
    logic dec;
    dec = (res >= THRESH);
`ifdef SONAR_FILTER_EN
    if (dec == model_prev[s] && dec != model_flag[s]) model_flag[s] = dec;
    model_prev[s] = dec;
`else
    model_flag[s] = dec;
`endif
    e.sel  = s;
    e.cnt  = res;
    e.flag = model_flag;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  // One measurement slot. Wait for the trigger, check which sensor fired and
  // for how long, then play the echo and queue the expected result.
  task automatic applyStimulus(input int s, input int width);
    int n;
    n = 0;
    while (trig == 4'b0000 && n < 6000) begin
      @(negedge clk_100);
      n++;
    end
    checkOutput("trig_sel", {28'd0, trig}, 32'(4'b0001 << s));
    n = 0;
    while (trig != 4'b0000 && n < 20) begin
      @(negedge clk_100);
      n++;
    end
    checkOutput("trig_width", n, TRIG_CYC);

    if (width == 0) begin
      pushResult(s, MAX_CNT, 0);
    end else begin
      repeat (ECHO_DELAY) @(negedge clk_100);
      echo[s]   = 1'b1;
      raise_cyc = cyc;
      if (width < 0) begin
        repeat (30) @(negedge clk_100);
        rst = 1'b1;
        @(negedge clk_100);
        checkOutput("abort_trig", {28'd0, trig}, 32'd0);
        checkOutput("abort_flag", {28'd0, distance_flag}, 32'hF);
        checkOutput("abort_valid", {31'd0, meas_valid}, 32'd0);
        model_flag = 4'b1111;
        model_prev = 4'b1111;
        echo[s]    = 1'b0;
        rst        = 1'b0;
      end else begin
        if (width >= MAX_CNT) pushResult(s, MAX_CNT, MAX_CNT + 2);
        else                  pushResult(s, width, width + 3);
        repeat (width) @(negedge clk_100);
        echo[s] = 1'b0;
      end
    end
  endtask

  // Scoreboard consumer: every meas_valid pulse must match the oldest queued
  // expectation.
  always @(negedge clk_100) begin
    exp_t e;
    if (!rst && meas_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("valid_unexpected", {31'd0, meas_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("meas_sel", {30'd0, meas_sel}, e.sel);
        checkOutput("meas_cnt", {20'd0, meas_cnt}, e.cnt);
        checkOutput("distance_flag", {28'd0, distance_flag}, {28'd0, e.flag});
        if (e.lat > 0) checkOutput("latency", cyc - raise_cyc, e.lat);
      end
    end
  end

  initial begin
    int n;
    $display("[TB] sonar_scan bench start");
    rst  = 1'b1;
    echo = 4'b0000;
    repeat (3) @(negedge clk_100);
    checkOutput("reset_trig", {28'd0, trig}, 32'd0);
    checkOutput("reset_flag", {28'd0, distance_flag}, 32'hF);
    checkOutput("reset_valid", {31'd0, meas_valid}, 32'd0);
    checkOutput("reset_sel", {30'd0, meas_sel}, 32'd0);
    checkOutput("reset_cnt", {20'd0, meas_cnt}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < PLAN_LEN; i++) begin
      applyStimulus(plan_sel[i], plan_width[i]);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_100);
      n++;
    end
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonar_scan.md
Name: sonar_scan

Overview:
- Upstream stage of the obstacle-avoidance controller. Drives four ultrasonic rangers (trigger/echo type) one at a time in a round-robin order, which avoids acoustic crosstalk.
- Times each echo pulse and compares it with a distance threshold.
- Produces the 4-bit `distance_flag` vector consumed by the avoidance FSM:
  - 1 = path clear
  - 0 = obstacle closer than the threshold
- Bit map: [3] left, [2] right, [1] front-left, [0] front-right.

Parameters:
- TRIG_CYC, 2: trigger high time in clock cycles (2 cycles = 20 us at 100 kHz).
- RISE_TO, 100: maximum cycles to wait for the echo to rise after the trigger ends.
- MAX_CNT, 3800: echo count saturation value (38 ms), treated as "no target".
- THRESH, 174: obstacle threshold in cycles (174 cycles ≈ 30 cm at 5.8 cycles/cm).
- GAP_CYC, 6000: settle gap after each measurement before the next sensor is triggered (60 ms).

Ports:
- clk_100  in  1  system clock, 100 kHz (10 us period); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- echo  in  4  raw echo inputs, asynchronous; bit i belongs to sensor i.
- trig  out  4  trigger outputs, one-hot or zero.
- distance_flag  out  4  per-sensor clear(1)/obstacle(0) flag.
- meas_valid  out  1  one-cycle pulse when a measurement completes.
- meas_sel  out  2  index of the sensor whose result is on `meas_cnt`.
- meas_cnt  out  12  last echo width in cycles (0..MAX_CNT).

Behaviour:
- **Echo synchronisation:** each echo bit passes through a 2-flop synchroniser before use. All references to echo below mean the synchronised value.
- **Reset values:** trig=0, distance_flag=4'b1111, meas_valid=0, meas_sel=0, meas_cnt=0. Internally: FSM=TRIG, sel=0, counters=0. Reset mid-operation aborts the measurement in progress: trig drops on the next edge and no flag is updated.
- **FSM states:** TRIG, WAIT_RISE, MEASURE, GAP. One shared 16-bit cycle counter `cnt`, cleared on every state change.
  - **TRIG:** trig[sel]=1, all other trig bits 0. After TRIG_CYC cycles, go to WAIT_RISE.
  - **WAIT_RISE:** trig=0. If echo[sel]=1, go to MEASURE with the echo counter set to 1. If cnt reaches RISE_TO first, the result is a timeout: result=MAX_CNT, then go to GAP.
  - **MEASURE:** the echo counter increments each cycle echo[sel]=1, saturating at MAX_CNT. Exit to GAP when echo[sel]=0 (result = counter) or when the counter reaches MAX_CNT (result = MAX_CNT, without waiting for the fall).
  - **GAP:** wait GAP_CYC cycles, then sel = sel+1 mod 4 (wraps 3→0), then go to TRIG.
- **Result registration:** on entry to GAP, for one cycle only:
  - meas_valid=1, meas_sel=sel, meas_cnt=result.
  - distance_flag[sel] = (result >= THRESH).
  - Other flag bits hold their value.
- **Threshold boundaries:**
  - result = THRESH gives clear (1); result = THRESH-1 gives obstacle (0).
  - Timeout and saturation both give clear.
- **Latency:** flag update is 1 cycle after the echo fall is seen on the synchroniser output (3 cycles after the raw fall).
- **Echo on non-selected sensors:** ignored entirely.
- **Echo already high during TRIG:** ignored. Counting starts only in WAIT_RISE.
- **Full sweep timing:** (TRIG_CYC + echo + wait + GAP_CYC) × 4. Defaults give ≥ 240 ms per sweep.
- **Output glitching:** distance_flag is registered and changes on at most one bit per measurement.

Optional Feature:
- Macro: SONAR_FILTER_EN.
- **Defined:** each sensor keeps a 1-bit record of its previous raw decision. distance_flag[sel] changes only when two consecutive measurements of that sensor agree with each other and differ from the current flag. A single contrary reading leaves the flag unchanged. Reset sets every previous decision to 1. meas_valid, meas_sel and meas_cnt are unaffected.
- **Undefined:** distance_flag[sel] takes each raw decision directly, as described above.

Test Plan:
- Release rst; hold echo=0 → trig sequence: trig=0001 for 2 cycles; after ≥100+6000+2 cycles, trig=0010; then 0100, 1000, 0001. Each timeout gives meas_valid with meas_cnt=3800, and distance_flag stays 1111.
- Sensor 1 echo rises 20 cycles after the trigger and stays high 100 cycles → meas_valid with meas_sel=1, meas_cnt=100, distance_flag=1101. Sensor 1 later echoes 200 cycles → flag back to 1111.
- Boundary: sensor 0 echo width 174 → flag[0]=1; width 173 → flag[0]=0.
- Sensor 3 echo held high indefinitely → meas_cnt=3800 exactly 3800 cycles after the rise, flag[3]=1, and sel wraps to 0 after the gap.
- Assert rst during MEASURE on sensor 2, with a prior flag of 1011 → next cycle: trig=0, flag=1111, meas_valid=0. Scanning restarts at sensor 0.
- With SONAR_FILTER_EN: sensor 2 echo widths 50, 300, 50, 50 → flag[2] stays 1, 1, 1, then becomes 0 after the fourth measurement.
